// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B4 arbiter that shares one slave among NUM_MASTERS classic-cycle masters.
// The grant is held for a whole CYC cycle. A watchdog ends a stalled strobe with an arbiter-generated ERR.
module wb_arbiter_rr #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  output logic [NUM_MASTERS-1:0]            gnt_o
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]           last_q, last_d;   // doubles as grantee index while busy
  logic [PW-1:0]           winner;
  logic                    found;
  logic [CW-1:0]           wd_cnt_q;
  logic                    g_stb;
  logic                    stalled;
  logic                    wd_err;

  logic [ADDR_WIDTH-1:0]   adr_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   dat_arr [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign adr_arr[k] = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_arr[k] = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_MASTERS) sum -= NUM_MASTERS;
    return PW'(sum);
  endfunction

  // Search starts just after the last owner so every requester is served in turn.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!found && m_cyc_i[rr_index(last_q, i)]) begin
        winner = rr_index(last_q, i);
        found  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= PW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BUSY;
          gnt_d   = NUM_MASTERS'(1) << winner;
          last_d  = winner;
        end
      end
      ST_BUSY: begin
        if (!m_cyc_i[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign g_stb   = (state_q == ST_BUSY) && m_stb_i[last_q];
  assign stalled = g_stb && !s_ack_i && !s_err_i;
  // A strobe that the slave terminates on the timeout cycle is not also errored by the watchdog.
  assign wd_err  = (TIMEOUT_CYCLES > 0) && stalled && (wd_cnt_q == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i || (TIMEOUT_CYCLES == 0) || !stalled || wd_err) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + CW'(1);
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state_q == ST_BUSY) begin
      s_cyc_o         = m_cyc_i[last_q];
      s_stb_o         = m_stb_i[last_q];
      s_we_o          = m_we_i[last_q];
      s_adr_o         = adr_arr[last_q];
      s_dat_o         = dat_arr[last_q];
      m_ack_o[last_q] = s_ack_i && g_stb && !s_err_i;
      m_err_o[last_q] = (s_err_i || wd_err) && g_stb;
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: directed scenarios followed by randomized masters and slave,
// all checked cycle by cycle against a transaction-level round-robin model.
module tb_wb_arbiter_rr;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o, s_dat_i;
  logic            s_ack_i, s_err_i;

  always #5 clk_i = ~clk_i;

  wb_arbiter_rr #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, who owned it last, and how long the current strobe has stalled.
  bit           mdl_busy  = 1'b0;
  int           mdl_owner = 0;
  int           mdl_last  = N - 1;
  int           stall_run = 0;
  bit           mdl_stalled, mdl_fire;
  logic [N-1:0] exp_ack_v = '0, exp_err_v = '0;

  logic [N-1:0]  obs_gnt, obs_ack, obs_err;
  logic          obs_cyc, obs_we;
  logic [AW-1:0] obs_adr;
  logic [DW-1:0] obs_dat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]  e_gnt, e_ack, e_err;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    int o;
    e_gnt = '0; e_ack = '0; e_err = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
    mdl_stalled = 1'b0;
    mdl_fire    = 1'b0;
    if (mdl_busy) begin
      o        = mdl_owner;
      e_gnt[o] = 1'b1;
      e_cyc    = m_cyc_i[o];
      e_stb    = m_stb_i[o];
      e_we     = m_we_i[o];
      e_adr    = m_adr_i[o*AW +: AW];
      e_dat    = m_dat_i[o*DW +: DW];
      mdl_stalled = m_stb_i[o] && !s_ack_i && !s_err_i;
      mdl_fire    = mdl_stalled && (stall_run == TO);
      e_ack[o] = s_ack_i && m_stb_i[o] && !s_err_i;
      e_err[o] = (s_err_i || mdl_fire) && m_stb_i[o];
    end
    check("gnt",   gnt_o,   e_gnt);
    check("s_cyc", s_cyc_o, e_cyc);
    check("s_stb", s_stb_o, e_stb);
    check("s_we",  s_we_o,  e_we);
    check("s_adr", s_adr_o, e_adr);
    check("s_dat", s_dat_o, e_dat);
    check("m_ack", m_ack_o, e_ack);
    check("m_err", m_err_o, e_err);
    check("m_dat", m_dat_o, s_dat_i);
    exp_ack_v = e_ack;
    exp_err_v = e_err;
    obs_gnt = gnt_o; obs_ack = m_ack_o; obs_err = m_err_o;
    obs_cyc = s_cyc_o; obs_we = s_we_o; obs_adr = s_adr_o; obs_dat = s_dat_o;
  endtask

  task automatic model_update();
    if (rst_i) begin
      mdl_busy  = 1'b0;
      mdl_last  = N - 1;
      stall_run = 0;
    end else if (!mdl_busy) begin
      stall_run = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (mdl_last + k) % N;
        if (m_cyc_i[c]) begin
          mdl_owner = c;
          mdl_last  = c;
          mdl_busy  = 1'b1;
          break;
        end
      end
    end else begin
      stall_run = (mdl_stalled && !mdl_fire) ? stall_run + 1 : 0;
      if (!m_cyc_i[mdl_owner]) mdl_busy = 1'b0;
    end
  endtask

  // Inputs are set after a falling edge; outputs are sampled mid low phase, before the rising edge.
  task automatic step();
    #2;
    compare_all();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc_i[k] = cyc;
    m_stb_i[k] = stb;
    m_we_i[k]  = we;
    m_adr_i[k*AW +: AW] = adr;
    m_dat_i[k*DW +: DW] = dat;
  endtask

  task automatic new_beat(input int k);
    m_we_i[k] = 1'($urandom);
    m_adr_i[k*AW +: AW] = AW'($urandom);
    m_dat_i[k*DW +: DW] = $urandom;
  endtask

  initial begin
    int unsigned ack_pct;
    rst_i = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_dat_i = 32'h5A5A_0001; s_ack_i = 1'b0; s_err_i = 1'b0;
    @(negedge clk_i);
    step();
    step();

    // Idle after reset: stray slave ACK/ERR must not reach any master.
    rst_i = 1'b0; s_ack_i = 1'b1; s_err_i = 1'b1;
    step();
    check("t1_gnt", obs_gnt, 3'b000);
    check("t1_cyc", obs_cyc, 1'b0);
    check("t1_ack", obs_ack, 3'b000);
    check("t1_err", obs_err, 3'b000);

    // Simultaneous requests: master0 first, one idle cycle, then master1 (write to 0x0004).
    s_ack_i = 1'b0; s_err_i = 1'b0;
    set_master(0, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h1111_1111);
    set_master(1, 1'b1, 1'b1, 1'b1, 16'h0004, 32'h0000_00AB);
    step();
    check("t2_latency", obs_gnt, 3'b000);
    s_ack_i = 1'b1;
    step();
    check("t2_gnt0", obs_gnt, 3'b001);
    check("t2_ack0", obs_ack, 3'b001);
    s_ack_i = 1'b0;
    set_master(0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
    step();
    check("t2_release_cyc", obs_cyc, 1'b0);
    step();
    check("t2_idle_gap", obs_gnt, 3'b000);
    step();
    check("t2_gnt1", obs_gnt, 3'b010);
    check("t3_adr", obs_adr, 16'h0004);
    check("t3_dat", obs_dat, 32'h0000_00AB);
    check("t3_we", obs_we, 1'b1);
    check("t3_no_ack_yet", obs_ack, 3'b000);
    step();
    s_ack_i = 1'b1;
    step();
    check("t3_ack", obs_ack, 3'b010);
    s_ack_i = 1'b0;
    set_master(1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
    set_master(0, 1'b1, 1'b1, 1'b0, 16'h0020, 32'h2222_2222);
    step();
    check("t3_ack_width", obs_ack, 3'b000);
    step();
    check("t2_gap2", obs_gnt, 3'b000);

    // ACK and ERR together: ERR wins.
    s_ack_i = 1'b1; s_err_i = 1'b1;
    step();
    check("t2_fair", obs_gnt, 3'b001);
    check("t5_err", obs_err, 3'b001);
    check("t5_ack", obs_ack, 3'b000);

    // Stalled strobe: watchdog ERR on the fifth stalled cycle, one cycle wide.
    s_ack_i = 1'b0; s_err_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_wd_early", obs_err, 3'b000);
    end
    step();
    check("t4_wd_err", obs_err, 3'b001);
    step();
    check("t4_wd_width", obs_err, 3'b000);

    // Reset mid-strobe drops the grant; the reset pointer favours master0 again.
    rst_i = 1'b1;
    set_master(1, 1'b1, 1'b1, 1'b0, 16'h0030, 32'h3333_3333);
    step();
    check("t6_pre", obs_gnt, 3'b001);
    rst_i = 1'b0;
    step();
    check("t6_gnt", obs_gnt, 3'b000);
    check("t6_cyc", obs_cyc, 1'b0);
    step();
    check("t6_ptr", obs_gnt, 3'b001);
    m_cyc_i = '0; m_stb_i = '0;
    step();
    step();

    // Randomized masters, slave responses and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < N; k++) begin
        if (!m_cyc_i[k]) begin
          if ($urandom_range(3) == 0) begin
            m_cyc_i[k] = 1'b1; m_stb_i[k] = 1'b1; new_beat(k);
          end
        end else if (m_stb_i[k] && (exp_ack_v[k] || exp_err_v[k])) begin
          if ($urandom_range(1) == 0) begin
            m_cyc_i[k] = 1'b0; m_stb_i[k] = 1'b0;
          end else begin
            m_stb_i[k] = 1'($urandom_range(1)); new_beat(k);
          end
        end else if (!m_stb_i[k]) begin
          m_stb_i[k] = 1'b1;
        end else if ($urandom_range(31) == 0) begin
          m_cyc_i[k] = 1'b0; m_stb_i[k] = 1'b0;
        end
      end
      case ((n / 300) % 3)
        0:       ack_pct = 60;
        1:       ack_pct = 15;
        default: ack_pct = 35;
      endcase
      s_ack_i = ($urandom_range(99) < ack_pct);
      s_err_i = ($urandom_range(19) == 0);
      s_dat_i = $urandom;
      rst_i   = ($urandom_range(249) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
